// File: rtl/apb_gpio_slave_if.sv
// APB bus bundle for the GPIO slave: master drives request fields, slave returns the
// registered response.
interface apb_gpio_slave_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [31:0]           PWDATA;
  logic [3:0]            PSTRB;
  logic [2:0]            PPROT;
  logic [31:0]           PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_gpio_slave.sv
// APB GPIO slave: DOUT/DIR/DIN/INT_EN/INT_STAT registers, one wait state per transfer,
// synchronized pin inputs with rising-edge interrupts.
module apb_gpio_slave #(
  parameter int GPIO_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  apb_gpio_slave_if.slave       apb,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic [GPIO_WIDTH-1:0] gpio_oe,
  output logic                  irq
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state_reg, state_next;
  logic                    commit;
  logic [GPIO_WIDTH-1:0]   dout_reg, dir_reg, int_en_reg, int_stat_reg;
  logic [GPIO_WIDTH-1:0]   sync1_reg, sync2_reg, prev_reg;
  logic [GPIO_WIDTH-1:0]   int_stat_next, rise, clr_bits, wmask, wbits;
  logic [31:0]             strb_mask, rd_val;
  logic [31:0]             prdata_reg;
  logic                    pready_reg, pslverr_reg, irq_reg;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [7:0]              offset;
  logic                    access, bad, wr_ok;
  logic                    unused_bits;

  assign paddr       = apb.PADDR;
  assign offset      = paddr[7:0];
  assign unused_bits = ^{paddr, apb.PPROT};
  assign access      = apb.PSEL & apb.PENABLE;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    commit     = 1'b0;
    case (state_reg)
      IDLE: if (access) state_next = WAIT;
      WAIT: begin
        if (access) begin
          state_next = RESP;
          commit     = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bad   = (offset[1:0] != 2'b00) || (offset > 8'h10) || (apb.PWRITE && offset == 8'h08);
  assign wr_ok = commit & apb.PWRITE & ~bad;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign strb_mask[gi*8 +: 8] = {8{apb.PSTRB[gi]}};
  end

  assign wmask = GPIO_WIDTH'(strb_mask);
  assign wbits = GPIO_WIDTH'(apb.PWDATA);

  always_comb begin
    rd_val = '0;
    case (offset)
      8'h00:   rd_val = 32'(dout_reg);
      8'h04:   rd_val = 32'(dir_reg);
      8'h08:   rd_val = 32'(sync2_reg);
      8'h0C:   rd_val = 32'(int_en_reg);
      8'h10:   rd_val = 32'(int_stat_reg);
      default: rd_val = '0;
    endcase
  end

  // A new rising edge takes priority over a W1C landing on the same bit.
  assign rise          = sync2_reg & ~prev_reg & int_en_reg;
  assign clr_bits      = (wr_ok && offset == 8'h10) ? (wbits & wmask) : '0;
  assign int_stat_next = (int_stat_reg & ~clr_bits) | rise;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      dout_reg     <= '0;
      dir_reg      <= '0;
      int_en_reg   <= '0;
      int_stat_reg <= '0;
      sync1_reg    <= '0;
      sync2_reg    <= '0;
      prev_reg     <= '0;
      irq_reg      <= 1'b0;
      prdata_reg   <= '0;
      pready_reg   <= 1'b0;
      pslverr_reg  <= 1'b0;
    end else begin
      sync1_reg    <= gpio_in;
      sync2_reg    <= sync1_reg;
      prev_reg     <= sync2_reg;
      int_stat_reg <= int_stat_next;
      irq_reg      <= |int_stat_reg;
      if (wr_ok && offset == 8'h00) dout_reg   <= (dout_reg   & ~wmask) | (wbits & wmask);
      if (wr_ok && offset == 8'h04) dir_reg    <= (dir_reg    & ~wmask) | (wbits & wmask);
      if (wr_ok && offset == 8'h0C) int_en_reg <= (int_en_reg & ~wmask) | (wbits & wmask);
      // Response fields live only for the single RESP cycle and are zero otherwise.
      pready_reg  <= commit;
      pslverr_reg <= commit & bad;
      prdata_reg  <= (commit && !apb.PWRITE && !bad) ? rd_val : '0;
    end
  end

  assign apb.PRDATA  = prdata_reg;
  assign apb.PREADY  = pready_reg;
  assign apb.PSLVERR = pslverr_reg;
  assign gpio_out    = dout_reg;
  assign gpio_oe     = dir_reg;
  assign irq         = irq_reg;

endmodule

// File: tb/tb_apb_gpio_slave.sv
// Bench for apb_gpio_slave: directed and random APB transfers against a register-level
// reference model that tracks pin history, registers and interrupt status.
module tb_apb_gpio_slave;
  localparam int GW = 16;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b0;
  logic [GW-1:0] gpio_in;
  logic [GW-1:0] gpio_out, gpio_oe;
  logic          irq;

  apb_gpio_slave_if #(.ADDR_WIDTH(32)) bus ();

  apb_gpio_slave #(.GPIO_WIDTH(GW), .ADDR_WIDTH(32)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .apb     (bus),
    .gpio_in (gpio_in),
    .gpio_out(gpio_out),
    .gpio_oe (gpio_oe),
    .irq     (irq)
  );

  always #5 PCLK = ~PCLK;

  int          vectors = 0;
  int          miscompares = 0;
  logic        commit_flag = 1'b0;
  logic [31:0] rv;
  logic        re;

  // Reference model: registers as plain values, pins as a history of sampled inputs.
  logic [GW-1:0] m_dout, m_dir, m_inten, m_istat;
  logic          m_irq;
  logic [GW-1:0] h0, h1, h2;
  logic [31:0]   exp_rdata;
  logic          exp_err;
  logic [7:0]    m_off;
  logic          m_bad;
  logic [GW-1:0] m_wmask, m_wdata, m_rise, m_clr;
  logic [31:0]   m_rdval;

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{s[i]}};
    return m;
  endfunction

  always_comb begin
    m_off   = bus.PADDR[7:0];
    m_bad   = (m_off % 4 != 0) || (m_off > 8'h10) || (bus.PWRITE && m_off == 8'h08);
    m_wmask = GW'(lane_mask(bus.PSTRB));
    m_wdata = GW'(bus.PWDATA);
    m_rise  = h1 & ~h2 & m_inten;
    m_clr   = '0;
    if (commit_flag && bus.PWRITE && !m_bad && m_off == 8'h10) m_clr = m_wdata & m_wmask;
    m_rdval = 32'h0;
    if (m_off == 8'h00) m_rdval = 32'(m_dout);
    if (m_off == 8'h04) m_rdval = 32'(m_dir);
    if (m_off == 8'h08) m_rdval = 32'(h1);
    if (m_off == 8'h0C) m_rdval = 32'(m_inten);
    if (m_off == 8'h10) m_rdval = 32'(m_istat);
  end

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      m_dout <= '0; m_dir <= '0; m_inten <= '0; m_istat <= '0; m_irq <= 1'b0;
      h0 <= '0; h1 <= '0; h2 <= '0; exp_rdata <= '0; exp_err <= 1'b0;
    end else begin
      h0 <= gpio_in; h1 <= h0; h2 <= h1;
      m_irq     <= (m_istat != 0);
      m_istat   <= (m_istat & ~m_clr) | m_rise;
      exp_rdata <= '0;
      exp_err   <= 1'b0;
      if (commit_flag) begin
        exp_err   <= m_bad;
        exp_rdata <= (m_bad || bus.PWRITE) ? 32'h0 : m_rdval;
        if (bus.PWRITE && !m_bad) begin
          if (m_off == 8'h00) m_dout  <= (m_dout  & ~m_wmask) | (m_wdata & m_wmask);
          if (m_off == 8'h04) m_dir   <= (m_dir   & ~m_wmask) | (m_wdata & m_wmask);
          if (m_off == 8'h0C) m_inten <= (m_inten & ~m_wmask) | (m_wdata & m_wmask);
        end
      end
    end
  end

  task automatic chk(input logic [31:0] got, input logic [31:0] exp, input string tag);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge PCLK);
    chk(32'(gpio_out), 32'(m_dout), "gpio_out");
    chk(32'(gpio_oe), 32'(m_dir), "gpio_oe");
    chk(32'(irq), 32'(m_irq), "irq");
    if (bus.PREADY !== 1'b1) begin
      chk(bus.PRDATA, 32'h0, "prdata_idle");
      chk(32'(bus.PSLVERR), 32'h0, "pslverr_idle");
    end
  endtask

  task automatic idle(input int n);
    bus.PSEL = 1'b0;
    bus.PENABLE = 1'b0;
    repeat (n) tick();
  endtask

  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input string tag);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = addr;
    bus.PWDATA = data; bus.PSTRB = strb; bus.PPROT = 3'($urandom);
    tick();
    chk(32'(bus.PREADY), 32'h0, {tag, "_setup_rdy"});
    bus.PENABLE = 1'b1;
    tick();
    chk(32'(bus.PREADY), 32'h0, {tag, "_wait_rdy"});
    commit_flag = 1'b1;
    tick();
    commit_flag = 1'b0;
    chk(32'(bus.PREADY), 32'h1, {tag, "_resp_rdy"});
    chk(32'(bus.PSLVERR), 32'(exp_err), {tag, "_slverr"});
    if (!wr) chk(bus.PRDATA, exp_rdata, {tag, "_rdata"});
    rv = bus.PRDATA;
    re = bus.PSLVERR;
    bus.PENABLE = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input string t);
    xfer(1'b1, a, d, s, t);
  endtask

  task automatic rd(input logic [31:0] a, input string t);
    xfer(1'b0, a, 32'h0, 4'h0, t);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] alist [8];
    int n;
    alist = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h02, 32'h100};
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = '0;
    bus.PWDATA = '0; bus.PSTRB = '0; bus.PPROT = '0;
    gpio_in = '0;
    repeat (3) @(negedge PCLK);
    chk(32'(bus.PREADY), 32'h0, "rst_pready");
    chk(32'(bus.PSLVERR), 32'h0, "rst_pslverr");
    chk(bus.PRDATA, 32'h0, "rst_prdata");
    chk(32'(irq), 32'h0, "rst_irq");
    chk(32'(gpio_out), 32'h0, "rst_gpio_out");
    chk(32'(gpio_oe), 32'h0, "rst_gpio_oe");
    PRESETn = 1'b1;
    idle(2);
    rd(32'h0C, "rst_inten"); chk(rv, 32'h0, "rst_inten_val");
    rd(32'h10, "rst_istat"); chk(rv, 32'h0, "rst_istat_val");

    // Byte-lane strobes and width masking
    wr(32'h00, 32'hA5A5_5A5A, 4'b0011, "dout_lo");
    rd(32'h00, "dout_rd"); chk(rv, 32'h0000_5A5A, "dout_strb_val"); chk(32'(re), 32'h0, "dout_rd_err");
    wr(32'h00, 32'h1234_FFFF, 4'b0100, "dout_hilane");
    rd(32'h00, "dout_rd2"); chk(rv, 32'h0000_5A5A, "dout_hilane_val");
    wr(32'h04, 32'hFFFF_FFFF, 4'hF, "dir_all");
    rd(32'h04, "dir_rd"); chk(rv, 32'h0000_FFFF, "dir_width_val");
    wr(32'h00, 32'h0000_1111, 4'h0, "strb0"); chk(32'(re), 32'h0, "strb0_err");
    rd(32'h00, "strb0_rd"); chk(rv, 32'h0000_5A5A, "strb0_val");

    // DIN is read-only; reads return the synchronized pins
    gpio_in = 16'hC3A5;
    idle(3);
    wr(32'h08, 32'hFFFF_FFFF, 4'hF, "din_wr"); chk(32'(re), 32'h1, "din_wr_err");
    rd(32'h08, "din_rd"); chk(rv, 32'h0000_C3A5, "din_val");

    // Decode errors
    rd(32'h14, "rd_14"); chk(32'(re), 32'h1, "rd_14_err"); chk(rv, 32'h0, "rd_14_data");
    rd(32'h02, "rd_02"); chk(32'(re), 32'h1, "rd_02_err"); chk(rv, 32'h0, "rd_02_data");

    // Rising-edge interrupt latency and W1C
    gpio_in = '0;
    idle(4);
    wr(32'h0C, 32'h1, 4'hF, "inten");
    wr(32'h10, 32'hFFFF_FFFF, 4'hF, "istat_clr");
    idle(1);
    gpio_in = 16'h0001;
    n = 0;
    while (irq !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk(32'(n), 32'd4, "irq_latency");
    rd(32'h10, "istat_rd"); chk(rv, 32'h1, "istat_set_val");
    wr(32'h10, 32'h1, 4'hF, "w1c");
    tick();
    chk(32'(irq), 32'h0, "irq_cleared");
    rd(32'h10, "istat_rd2"); chk(rv, 32'h0, "istat_clr_val");

    // Edge arriving on the same edge as the W1C commit keeps the bit set
    gpio_in = '0; idle(4);
    gpio_in = 16'h0001; idle(4);
    gpio_in = '0; idle(4);
    gpio_in = 16'h0001;
    wr(32'h10, 32'h1, 4'hF, "w1c_race");
    rd(32'h10, "race_rd"); chk(rv, 32'h1, "set_wins_val");

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 0) gpio_in = GW'($urandom);
      xfer(1'($urandom), alist[$urandom_range(0, 7)], $urandom, 4'($urandom), "rnd");
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    // Access dropped during the wait state leaves registers untouched
    idle(1);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 32'h0;
    bus.PWDATA = ~32'(m_dout); bus.PSTRB = 4'hF;
    tick();
    bus.PENABLE = 1'b1;
    tick();
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    tick();
    chk(32'(bus.PREADY), 32'h0, "drop_pready");
    tick();

    // Reset during the wait state of a DIR write aborts it
    wr(32'h04, 32'h0000_000F, 4'hF, "dir_pre");
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 32'h04;
    bus.PWDATA = 32'h0000_00FF; bus.PSTRB = 4'hF;
    tick();
    bus.PENABLE = 1'b1;
    tick();
    PRESETn = 1'b0;
    #1;
    chk(32'(bus.PREADY), 32'h0, "abort_pready");
    chk(32'(gpio_oe), 32'h0, "abort_dir");
    chk(32'(bus.PSLVERR), 32'h0, "abort_pslverr");
    tick();
    PRESETn = 1'b1;
    idle(2);
    wr(32'h04, 32'h0000_00AA, 4'hF, "dir_post");
    rd(32'h04, "dir_post_rd"); chk(rv, 32'h0000_00AA, "dir_post_val"); chk(32'(re), 32'h0, "dir_post_err");
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
